fpu_result_buffer: RTL and testbench
====================================

Name: fpu_result_buffer

Overview:
- Output stage directly downstream of the FPU's fixed-latency result pipeline (non-stallable delay chain).
- Captures each result/flags word leaving the pipeline into a small FIFO and presents it to the consumer over a valid/ready handshake.
- Because the pipeline cannot stall, the block also runs a credit counter and tells upstream issue logic when a new operation may enter, guaranteeing a FIFO slot for every in-flight result.

Parameters:
- WIDTH, 32, result data width.
- FLAG_W, 5, exception-flag width (NV, DZ, OF, UF, NX).
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all state on rising edge.
- arst_n  input  1  asynchronous active-low reset.
- issue_valid  input  1  upstream wants to launch an op into the pipeline this cycle.
- issue_ok  output  1  credit available; an op is launched only when issue_valid && issue_ok.
- res_valid  input  1  pipeline result valid (delay-chain output).
- res_data  input  WIDTH  pipeline result.
- res_flags  input  FLAG_W  pipeline flags.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  WIDTH  head result.
- out_flags  output  FLAG_W  head flags.
- count  output  $clog2(DEPTH+1)  FIFO occupancy.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (async assert, sync release): rd/wr pointers 0, count 0, reserved 0, proto_err 0. Outputs: out_valid 0, out_data 0, out_flags 0, issue_ok 1. Storage contents don't care.
- reserved counter, width $clog2(DEPTH+1); tracks in-flight ops + stored entries.
  - +1 on accept (issue_valid && issue_ok); -1 on pop (out_valid && out_ready); both in one cycle: unchanged.
- issue_ok = (reserved != DEPTH), from registered state only. A same-cycle pop does not raise issue_ok; it rises the cycle after.
- issue_valid while issue_ok=0: ignored, no state change.
- Push: res_valid=1 writes {res_data,res_flags} at wr_ptr, wr_ptr+1 mod DEPTH, count+1.
- Pop: out_valid && out_ready advances rd_ptr mod DEPTH, count-1.
- Push and pop in the same cycle: both occur, count unchanged, including at count=DEPTH.
- Latency: result pushed in cycle N shows out_valid=1 in cycle N+1. No fall-through, except with the optional feature below.
- out_valid = (count != 0). out_data/out_flags show the head entry when valid and are forced to 0 when count=0.
- Ordering: strict FIFO; results leave in arrival order.
- Full, push, no pop: proto_err set, write dropped, state unchanged.
- proto_err is also set on res_valid when reserved == count (no op in flight); that result is still written if space exists.
- proto_err is sticky until reset.
- Empty with out_ready=1: no pop; pointers hold.
- Reset mid-operation: all entries and credits discarded immediately. The upstream delay chain shares arst_n, so no stale results arrive afterwards.

Optional Feature:
- Macro: FPU_RESBUF_BYPASS_EN.
- Defined: when count=0, res_valid=1 and out_ready=1 in the same cycle:
  - out_valid=1 with out_data=res_data and out_flags=res_flags combinationally.
  - Result consumed without a write; reserved -1; count stays 0.
  - If count=0 and out_ready=0, the result is written normally.
- Undefined: no combinational path from res_* to out_*; one-cycle minimum latency always.

Test Plan:
- Reset with arst_n low mid-stream (count=2) -> same cycle: out_valid=0, count=0, issue_ok=1, proto_err=0, out_data=0.
- DEPTH=4, out_ready=0, issue_valid=1 for 5 cycles, results 0x3F800000, 0x40000000, 0x40400000, 0x40800000 arriving 2 cycles after issue -> exactly 4 accepts; issue_ok=0 from the cycle after the 4th accept; count=4; out_data=0x3F800000.
- Then out_ready=1 for 4 cycles -> out_data sequence 0x3F800000, 0x40000000, 0x40400000, 0x40800000 with flags intact; issue_ok=1 the cycle after the first pop; count back to 0, out_valid=0.
- reserved=4, count=4, out_ready=1, issue_valid=1 -> no accept that cycle; next cycle issue_ok=1, accept, reserved=4.
- Full FIFO, res_valid=1 with 0xDEADBEEF, out_ready=0 -> proto_err=1 stays set, count=4, 0xDEADBEEF never appears. Separately, res_valid with reserved=0 -> proto_err=1, count=1.
- With FPU_RESBUF_BYPASS_EN, empty, one op issued, out_ready=1, res_valid with 0x3F800000 -> same cycle out_valid=1, out_data=0x3F800000; count stays 0; reserved returns to 0. Without the macro -> out_valid in the following cycle.

Source files
------------

// File: rtl/fpu_result_buffer.sv
// Result FIFO behind the FPU's non-stallable delay chain, with issue credits so every in-flight op has a slot.
// Optional same-cycle bypass of an empty FIFO is enabled by defining FPU_RESBUF_BYPASS_EN.
module fpu_result_buffer #(
    parameter int WIDTH  = 32,
    parameter int FLAG_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       issue_valid,
    output logic                       issue_ok,
    input  logic                       res_valid,
    input  logic [WIDTH-1:0]           res_data,
    input  logic [FLAG_W-1:0]          res_flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [FLAG_W-1:0]          out_flags,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       proto_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = WIDTH + FLAG_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] reserved;
    logic          err_q;

    logic empty;
    logic full;
    logic accept;
    logic bypass;
    logic pop_mem;
    logic push_mem;
    logic release_cr;
    logic err_set;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_CNT);
    assign accept = issue_valid && issue_ok;

`ifdef FPU_RESBUF_BYPASS_EN
    assign bypass = empty && res_valid && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign pop_mem    = !empty && out_ready;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign push_mem   = res_valid && !bypass && (!full || pop_mem);
    assign release_cr = pop_mem || bypass;
    assign err_set    = res_valid && ((reserved == count_q) || (full && !pop_mem));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            reserved <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push_mem) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_mem) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_mem && !pop_mem) begin
                count_q <= count_q + CW'(1);
            end else if (pop_mem && !push_mem) begin
                count_q <= count_q - CW'(1);
            end
            // Saturate at zero so a stray result (no credit) cannot wrap the credit count.
            if (accept && !release_cr) begin
                reserved <= reserved + CW'(1);
            end else if (release_cr && !accept && (reserved != '0)) begin
                reserved <= reserved - CW'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; validity is carried entirely by count/pointers.
    always_ff @(posedge clk) begin
        if (push_mem) begin
            mem[wr_ptr] <= {res_data, res_flags};
        end
    end

    assign issue_ok  = (reserved != FULL_CNT);
    assign count     = count_q;
    assign proto_err = err_q;

`ifdef FPU_RESBUF_BYPASS_EN
    assign out_valid = !empty || bypass;
    assign out_data  = bypass ? res_data  : (empty ? '0 : mem[rd_ptr][EW-1:FLAG_W]);
    assign out_flags = bypass ? res_flags : (empty ? '0 : mem[rd_ptr][FLAG_W-1:0]);
`else
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr][EW-1:FLAG_W];
    assign out_flags = empty ? '0 : mem[rd_ptr][FLAG_W-1:0];
`endif

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Scoreboard bench for fpu_result_buffer: queue-based reference model checked every cycle plus directed scenarios.
module tb_fpu_result_buffer;
    localparam int WIDTH  = 32;
    localparam int FLAG_W = 5;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int EW     = WIDTH + FLAG_W;

    logic              clk;
    logic              arst_n;
    logic              issue_valid;
    logic              issue_ok;
    logic              res_valid;
    logic [WIDTH-1:0]  res_data;
    logic [FLAG_W-1:0] res_flags;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [FLAG_W-1:0] out_flags;
    logic [CW-1:0]     count;
    logic              proto_err;

    int total = 0;
    int bad   = 0;
    int accepts;

    logic [EW-1:0] sb[$];
    int            m_res;
    bit            m_err;
    logic [31:0]   vals[4];

    fpu_result_buffer #(.WIDTH(WIDTH), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .arst_n(arst_n),
        .issue_valid(issue_valid), .issue_ok(issue_ok),
        .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags),
        .count(count), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare this cycle's outputs with the model, advance the model, then step one clock.
    task automatic tick();
        bit byp;
        bit pop_e;
        bit acc;
        logic [EW-1:0] exp_e;
`ifdef FPU_RESBUF_BYPASS_EN
        byp = (sb.size() == 0) && res_valid && out_ready;
`else
        byp = 1'b0;
`endif
        chk("issue_ok", issue_ok, m_res != DEPTH);
        chk("count", count, sb.size());
        chk("proto_err", proto_err, m_err);
        chk("out_valid", out_valid, byp || sb.size() != 0);
        if (byp) exp_e = {res_data, res_flags};
        else if (sb.size() != 0) exp_e = sb[0];
        else exp_e = '0;
        chk("out_word", {out_data, out_flags}, exp_e);
        acc   = issue_valid && (m_res != DEPTH);
        accepts += int'(acc);
        pop_e = out_ready && (byp || sb.size() != 0);
        if (res_valid && m_res == sb.size()) m_err = 1'b1;
        if (pop_e && !byp) void'(sb.pop_front());
        if (res_valid && !byp) begin
            if (sb.size() == DEPTH) m_err = 1'b1;
            else sb.push_back({res_data, res_flags});
        end
        m_res = m_res + int'(acc) - int'(pop_e);
        if (m_res < 0) m_res = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        res_valid   = 1'b0;
        out_ready   = 1'b0;
        res_data    = '0;
        res_flags   = '0;
    endtask

    task automatic model_reset();
        sb.delete();
        m_res = 0;
        m_err = 1'b0;
    endtask

    // Issue n ops (out_ready=0); each result arrives two cycles after its issue.
    task automatic fill(input int n);
        for (int c = 0; c < n + 2; c++) begin
            issue_valid = (c < n);
            res_valid   = (c >= 2);
            res_data    = (c >= 2) ? vals[(c - 2) % 4] : 32'h0;
            res_flags   = FLAG_W'(c + 1);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        bit p0;
        bit p1;
        bit acc;
        vals[0] = 32'h3F800000;
        vals[1] = 32'h40000000;
        vals[2] = 32'h40400000;
        vals[3] = 32'h40800000;
        idle_inputs();
        model_reset();
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ok", issue_ok, 1);
        chk("rst_count", count, 0);
        arst_n = 1'b1;
        tick();

        // Five issue requests against four credits.
        accepts = 0;
        for (int c = 0; c < 6; c++) begin
            issue_valid = (c < 5);
            res_valid   = (c >= 2);
            res_data    = (c >= 2) ? vals[c - 2] : 32'h0;
            res_flags   = FLAG_W'(c + 1);
            if (c == 4) chk("no_credit", issue_ok, 0);
            tick();
        end
        idle_inputs();
        chk("accepts", accepts, 4);
        chk("full_count", count, 4);
        chk("full_head", out_data, 32'h3F800000);

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) chk("ok_after_pop", issue_ok, 1);
            chk("drain_data", out_data, vals[i]);
            chk("drain_flags", out_flags, FLAG_W'(i + 3));
            tick();
        end
        out_ready = 1'b0;
        chk("empty_count", count, 0);
        chk("empty_valid", out_valid, 0);

        // Same-cycle pop does not free a credit until the next cycle.
        fill(4);
        out_ready   = 1'b1;
        issue_valid = 1'b1;
        chk("pop_no_acc", issue_ok, 0);
        tick();
        out_ready = 1'b0;
        chk("ok_next", issue_ok, 1);
        tick();
        issue_valid = 1'b0;
        chk("reserved_full", issue_ok, 0);
        tick();
        res_valid = 1'b1;
        res_data  = 32'h41000000;
        res_flags = 5'h11;
        tick();
        chk("refull", count, 4);
        chk("no_err_yet", proto_err, 0);
        res_data = 32'hDEADBEEF;
        tick();
        res_valid = 1'b0;
        chk("ovf_err", proto_err, 1);
        chk("ovf_count", count, 4);
        tick();
        chk("err_sticky", proto_err, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("no_dead", out_data == 32'hDEADBEEF, 0);
            tick();
        end
        out_ready = 1'b0;

        // Asynchronous reset in the middle of traffic.
        fill(2);
        chk("pre_rst_count", count, 2);
        arst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_count", count, 0);
        chk("mrst_ok", issue_ok, 1);
        chk("mrst_err", proto_err, 0);
        chk("mrst_data", out_data, 0);
        model_reset();
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // Result with no op in flight.
        res_valid = 1'b1;
        res_data  = 32'h12345678;
        res_flags = 5'h04;
        tick();
        res_valid = 1'b0;
        chk("stray_err", proto_err, 1);
        chk("stray_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        arst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // Empty buffer, consumer ready when the result lands.
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        tick();
        res_valid = 1'b1;
        res_data  = 32'h3F800000;
        res_flags = 5'h01;
        out_ready = 1'b1;
`ifdef FPU_RESBUF_BYPASS_EN
        chk("byp_valid", out_valid, 1);
        chk("byp_data", out_data, 32'h3F800000);
        chk("byp_flags", out_flags, 5'h01);
`else
        chk("nobyp_valid", out_valid, 0);
`endif
        tick();
        res_valid = 1'b0;
`ifdef FPU_RESBUF_BYPASS_EN
        chk("byp_count", count, 0);
        chk("byp_valid_after", out_valid, 0);
`else
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 32'h3F800000);
`endif
        tick();
        out_ready = 1'b0;
        chk("byp_credit", issue_ok, 1);
        chk("byp_err", proto_err, 0);

        // Random traffic through a two-stage pipeline model.
        p0 = 1'b0;
        p1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            issue_valid = (c < 380) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready   = ($urandom_range(0, 3) != 0);
            res_valid   = p1;
            res_data    = $urandom;
            res_flags   = FLAG_W'($urandom);
            acc = issue_valid && (m_res != DEPTH);
            tick();
            p1 = p0;
            p0 = acc;
        end
        idle_inputs();
        chk("rand_err", proto_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
